pe_sync_ctrl: RTL and testbench

Join/fork sequencer for one compute node of the network. It collects one flit from each enabled input stream (cast, merge, gather), models a fixed compute latency, then emits the result once on each enabled output stream. Each output stream may accept in a different cycle. It counts completed tokens, flags start and completion, and halts after a programmed token total. It sits between the node's router-side cast/merge/gather ports and the PE compute stub, and replaces the purely combinational all-valid/all-ready coupling.

---
 rtl/pe_sync_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pe_sync_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sync_ctrl.sv
// pe_sync_ctrl -- join/fork sequencer for one compute node.
//
// Collects one flit from each enabled input stream (cast always, merge and
// gather when enabled), waits COMPUTE_LAT cycles, then offers the sum of the
// collected flits once on every enabled output stream.  Each output may be
// accepted in a different cycle.  Completed tokens are counted.  After TOTAL
// tokens the block parks in DONE until rst.
//
// Optional feature macro: PE_CTRL_STATS_EN builds the input/output stall
// counters.  Without it, stall_in_o and stall_out_o are tied to 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cast/merge/gather_*_i/_o      input streams: data, valid in, ready out
//   cast/merge/gather_*_o/_i      output streams: data, valid out, ready in
//   start_o                       pulse on the first cast accept after reset
//   done_o                        high while in DONE
//   count_o                       completed token count
//   stall_in_o, stall_out_o       stall cycle counters (stats build only)
//
// The data width comes from the DW macro; it defaults to 8 if the build does
// not provide it.

`ifndef DW
`define DW 8
`endif

module pe_sync_ctrl #(
  parameter int CAST_OUT    = 0,
  parameter int MERGE_IN    = 0,
  parameter int MERGE_OUT   = 0,
  parameter int GATHER_IN   = 0,
  parameter int GATHER_OUT  = 0,
  parameter int COMPUTE_LAT = 4,
  parameter int TOTAL       = 10000,
  parameter int X           = 0,
  parameter int Y           = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [`DW-1:0]   cast_data_i,
  input  logic             cast_valid_i,
  output logic             cast_ready_o,
  input  logic [`DW-1:0]   merge_data_i,
  input  logic             merge_valid_i,
  output logic             merge_ready_o,
  input  logic [`DW-1:0]   gather_data_i,
  input  logic             gather_valid_i,
  output logic             gather_ready_o,
  output logic [`DW-1:0]   cast_data_o,
  output logic             cast_valid_o,
  input  logic             cast_ready_i,
  output logic [`DW-1:0]   merge_data_o,
  output logic             merge_valid_o,
  input  logic             merge_ready_i,
  output logic [`DW-1:0]   gather_data_o,
  output logic             gather_valid_o,
  input  logic             gather_ready_i,
  output logic             start_o,
  output logic             done_o,
  output logic [31:0]      count_o,
  output logic [31:0]      stall_in_o,
  output logic [31:0]      stall_out_o
);

  // Merge-only output mode overrides the cast and gather output enables.
  localparam bit MERGE_IN_EN   = (MERGE_IN != 0);
  localparam bit GATHER_IN_EN  = (GATHER_IN != 0);
  localparam bit MERGE_OUT_EN  = (MERGE_OUT != 0);
  localparam bit CAST_OUT_EN   = (CAST_OUT != 0) && !MERGE_OUT_EN;
  localparam bit GATHER_OUT_EN = (GATHER_OUT != 0) && !MERGE_OUT_EN;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             got_cast, got_merge, got_gather;
  logic             sent_cast, sent_merge, sent_gather;
  logic [`DW-1:0]   hold_cast, hold_merge, hold_gather;
  logic [`DW-1:0]   result;
  logic [7:0]       lat_cnt;
  logic [31:0]      count;
  logic             started;

  logic             cast_acc, merge_acc, gather_acc;
  logic             cast_oacc, merge_oacc, gather_oacc;
  logic             all_got, all_sent;
  logic [31:0]      count_inc;
  logic [`DW-1:0]   sum;

  // Node coordinates only label simulation messages; keep them referenced.
  logic unused_coords;
  assign unused_coords = X[0] ^ Y[0];

  // Handshake decode: ready/valid depend on state and flags only.  rst masks
  // them so every handshake output reads 0 while reset is applied.
  always_comb begin
    cast_ready_o   = !rst && (state == COLLECT) && !got_cast;
    merge_ready_o  = MERGE_IN_EN  && !rst && (state == COLLECT) && !got_merge;
    gather_ready_o = GATHER_IN_EN && !rst && (state == COLLECT) && !got_gather;
    cast_valid_o   = CAST_OUT_EN   && !rst && (state == EMIT) && !sent_cast;
    merge_valid_o  = MERGE_OUT_EN  && !rst && (state == EMIT) && !sent_merge;
    gather_valid_o = GATHER_OUT_EN && !rst && (state == EMIT) && !sent_gather;

    cast_acc    = cast_valid_i   && cast_ready_o;
    merge_acc   = merge_valid_i  && merge_ready_o;
    gather_acc  = gather_valid_i && gather_ready_o;
    cast_oacc   = cast_valid_o   && cast_ready_i;
    merge_oacc  = merge_valid_o  && merge_ready_i;
    gather_oacc = gather_valid_o && gather_ready_i;

    // Captures landing this cycle count towards completion of the join.
    all_got  = (got_cast || cast_acc)
            && (!MERGE_IN_EN  || got_merge  || merge_acc)
            && (!GATHER_IN_EN || got_gather || gather_acc);
    all_sent = (!CAST_OUT_EN   || sent_cast   || cast_oacc)
            && (!MERGE_OUT_EN  || sent_merge  || merge_oacc)
            && (!GATHER_OUT_EN || sent_gather || gather_oacc);

    // Sum uses the live input for any flit captured in the exit cycle.
    sum = cast_acc ? cast_data_i : hold_cast;
    if (MERGE_IN_EN) begin
      sum = sum + (merge_acc ? merge_data_i : hold_merge);
    end else begin
      sum = sum + {`DW{1'b0}};
    end
    if (GATHER_IN_EN) begin
      sum = sum + (gather_acc ? gather_data_i : hold_gather);
    end else begin
      sum = sum + {`DW{1'b0}};
    end

    count_inc = count + 32'd1;
    start_o   = cast_acc && !started;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (all_got) begin
          state_next = (COMPUTE_LAT == 0) ? EMIT : COMPUTE;
        end else begin
          state_next = COLLECT;
        end
      end
      COMPUTE: begin
        if (lat_cnt == 8'd1) begin
          state_next = EMIT;
        end else begin
          state_next = COMPUTE;
        end
      end
      EMIT: begin
        if (all_sent) begin
          state_next = (count_inc == TOTAL[31:0]) ? DONE : COLLECT;
        end else begin
          state_next = EMIT;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  // State register, join/fork flags, token counter and start tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      got_cast    <= 1'b0;
      got_merge   <= 1'b0;
      got_gather  <= 1'b0;
      sent_cast   <= 1'b0;
      sent_merge  <= 1'b0;
      sent_gather <= 1'b0;
      count       <= 32'd0;
      started     <= 1'b0;
    end else begin
      state <= state_next;
      if (cast_acc)    got_cast    <= 1'b1;
      if (merge_acc)   got_merge   <= 1'b1;
      if (gather_acc)  got_gather  <= 1'b1;
      if (cast_oacc)   sent_cast   <= 1'b1;
      if (merge_oacc)  sent_merge  <= 1'b1;
      if (gather_oacc) sent_gather <= 1'b1;
      if (cast_acc)    started     <= 1'b1;
      if ((state == EMIT) && all_sent) begin
        count       <= count_inc;
        got_cast    <= 1'b0;
        got_merge   <= 1'b0;
        got_gather  <= 1'b0;
        sent_cast   <= 1'b0;
        sent_merge  <= 1'b0;
        sent_gather <= 1'b0;
      end
    end
  end

  // Datapath: hold registers, result snapshot on join completion, latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cast   <= {`DW{1'b0}};
      hold_merge  <= {`DW{1'b0}};
      hold_gather <= {`DW{1'b0}};
      result      <= {`DW{1'b0}};
      lat_cnt     <= 8'd0;
    end else begin
      if (cast_acc)   hold_cast   <= cast_data_i;
      if (merge_acc)  hold_merge  <= merge_data_i;
      if (gather_acc) hold_gather <= gather_data_i;
      if ((state == COLLECT) && all_got) begin
        result  <= sum;
        lat_cnt <= COMPUTE_LAT[7:0];
      end else if (state == COMPUTE) begin
        lat_cnt <= lat_cnt - 8'd1;
      end
    end
  end

  assign cast_data_o   = result;
  assign merge_data_o  = result;
  assign gather_data_o = result;
  assign done_o        = (state == DONE);
  assign count_o       = count;

`ifdef PE_CTRL_STATS_EN
  logic [31:0] stall_in, stall_out;
  logic        in_starved, out_blocked;

  // Stall conditions: an outstanding input with no data, or an outstanding
  // output whose consumer is not ready.
  always_comb begin
    in_starved  = (state == COLLECT)
               && ((!got_cast && !cast_valid_i)
                || (MERGE_IN_EN  && !got_merge  && !merge_valid_i)
                || (GATHER_IN_EN && !got_gather && !gather_valid_i));
    out_blocked = (state == EMIT)
               && ((CAST_OUT_EN   && !sent_cast   && !cast_ready_i)
                || (MERGE_OUT_EN  && !sent_merge  && !merge_ready_i)
                || (GATHER_OUT_EN && !sent_gather && !gather_ready_i));
  end

  // Saturating stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_in  <= 32'd0;
      stall_out <= 32'd0;
    end else begin
      if (in_starved && (stall_in != 32'hFFFF_FFFF))   stall_in  <= stall_in + 32'd1;
      if (out_blocked && (stall_out != 32'hFFFF_FFFF)) stall_out <= stall_out + 32'd1;
    end
  end

  assign stall_in_o  = stall_in;
  assign stall_out_o = stall_out;
`else
  assign stall_in_o  = 32'd0;
  assign stall_out_o = 32'd0;
`endif

endmodule

// File: tb/tb_pe_sync_ctrl.sv
// Directed bench for pe_sync_ctrl.  Four instances with different parameter
// sets share the input-side stimulus; only the instance under test is out of
// reset at any time.
//   0: CAST_OUT, COMPUTE_LAT=0, TOTAL=4            streaming and DONE
//   1: MERGE_IN, GATHER_IN, CAST_OUT, LAT=3        staggered join, wrap, rst
//   2: CAST_OUT, GATHER_OUT, LAT=1                 independent output accepts
//   3: MERGE_OUT with CAST_OUT, GATHER_OUT, LAT=0  merge-only output

`ifndef DW
`define DW 8
`endif

module tb_pe_sync_ctrl;
  localparam int DW = `DW;

  logic clk = 1'b0;
  logic [3:0] rst;
  logic [DW-1:0] cast_di, merge_di, gather_di;
  logic cast_vi, merge_vi, gather_vi;
  logic cast_ri, merge_ri, gather_ri;

  logic [DW-1:0] cast_do [4];
  logic [DW-1:0] merge_do [4];
  logic [DW-1:0] gather_do [4];
  logic cast_vo [4];
  logic merge_vo [4];
  logic gather_vo [4];
  logic cast_ro [4];
  logic merge_ro [4];
  logic gather_ro [4];
  logic start [4];
  logic done [4];
  logic [31:0] count [4];
  logic [31:0] stall_in [4];
  logic [31:0] stall_out [4];

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pe_sync_ctrl #(
      .CAST_OUT   (1),
      .MERGE_IN   ((g == 1) ? 1 : 0),
      .MERGE_OUT  ((g == 3) ? 1 : 0),
      .GATHER_IN  ((g == 1) ? 1 : 0),
      .GATHER_OUT ((g == 2 || g == 3) ? 1 : 0),
      .COMPUTE_LAT((g == 1) ? 3 : ((g == 2) ? 1 : 0)),
      .TOTAL      ((g == 0) ? 4 : 10),
      .X          (g),
      .Y          (0)
    ) dut (
      .clk           (clk),
      .rst           (rst[g]),
      .cast_data_i   (cast_di),
      .cast_valid_i  (cast_vi),
      .cast_ready_o  (cast_ro[g]),
      .merge_data_i  (merge_di),
      .merge_valid_i (merge_vi),
      .merge_ready_o (merge_ro[g]),
      .gather_data_i (gather_di),
      .gather_valid_i(gather_vi),
      .gather_ready_o(gather_ro[g]),
      .cast_data_o   (cast_do[g]),
      .cast_valid_o  (cast_vo[g]),
      .cast_ready_i  (cast_ri),
      .merge_data_o  (merge_do[g]),
      .merge_valid_o (merge_vo[g]),
      .merge_ready_i (merge_ri),
      .gather_data_o (gather_do[g]),
      .gather_valid_o(gather_vo[g]),
      .gather_ready_i(gather_ri),
      .start_o       (start[g]),
      .done_o        (done[g]),
      .count_o       (count[g]),
      .stall_in_o    (stall_in[g]),
      .stall_out_o   (stall_out[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 4'b1111;
    cast_di = '0; merge_di = '0; gather_di = '0;
    cast_vi = 1'b0; merge_vi = 1'b0; gather_vi = 1'b0;
    cast_ri = 1'b0; merge_ri = 1'b0; gather_ri = 1'b0;

    // ---------------- instance 0: reset values, streaming, DONE
    cyc(); cyc(); #1;
    check("rst_count", count[0], 32'd0);
    check("rst_cast_ready", {31'd0, cast_ro[0]}, 32'd0);
    check("rst_cast_valid", {31'd0, cast_vo[0]}, 32'd0);
    check("rst_done", {31'd0, done[0]}, 32'd0);
    check("rst_start", {31'd0, start[0]}, 32'd0);
    check("rst_data", {24'd0, cast_do[0]}, 32'd0);

    cyc();
    rst[0] = 1'b0;
    cast_vi = 1'b1;
    cast_ri = 1'b1; merge_ri = 1'b1; gather_ri = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cast_di = DW'(k);
      #1;
      check("a_collect_ready", {31'd0, cast_ro[0]}, 32'd1);
      check("a_start", {31'd0, start[0]}, (k == 1) ? 32'd1 : 32'd0);
      cyc(); #1;
      check("a_emit_valid", {31'd0, cast_vo[0]}, 32'd1);
      check("a_emit_data", {24'd0, cast_do[0]}, 32'(k));
      check("a_emit_ready", {31'd0, cast_ro[0]}, 32'd0);
      check("a_emit_count", count[0], 32'(k - 1));
      cyc();
    end
    #1;
    check("a_done", {31'd0, done[0]}, 32'd1);
    check("a_done_count", count[0], 32'd4);
    check("a_done_ready", {31'd0, cast_ro[0]}, 32'd0);
    check("a_done_valid", {31'd0, cast_vo[0]}, 32'd0);
    cyc(); #1;
    check("a_done_hold_ready", {31'd0, cast_ro[0]}, 32'd0);
    check("a_done_hold", {31'd0, done[0]}, 32'd1);
    cast_vi = 1'b0;
    rst[0] = 1'b1;

    // ---------------- instance 1: staggered join (cycle 0 = first after rst)
    cast_ri = 1'b0;
    cyc();
    rst[1] = 1'b0;
    cast_vi = 1'b1; cast_di = 8'd5;
    #1;
    check("b_c0_cast_ready", {31'd0, cast_ro[1]}, 32'd1);
    check("b_c0_merge_ready", {31'd0, merge_ro[1]}, 32'd1);
    check("b_c0_gather_ready", {31'd0, gather_ro[1]}, 32'd1);
    check("b_c0_start", {31'd0, start[1]}, 32'd1);
    cyc(); cast_vi = 1'b0; #1;
    check("b_c1_cast_ready", {31'd0, cast_ro[1]}, 32'd0);
    check("b_c1_merge_ready", {31'd0, merge_ro[1]}, 32'd1);
    cyc(); merge_vi = 1'b1; merge_di = 8'd7; #1;
    check("b_c2_merge_ready", {31'd0, merge_ro[1]}, 32'd1);
    cyc(); merge_vi = 1'b0; #1;
    check("b_c3_merge_ready", {31'd0, merge_ro[1]}, 32'd0);
    check("b_c3_gather_ready", {31'd0, gather_ro[1]}, 32'd1);
    cyc(); gather_vi = 1'b1; gather_di = 8'd9; #1;
    check("b_c4_gather_ready", {31'd0, gather_ro[1]}, 32'd1);
    cyc(); gather_vi = 1'b0; #1;
    check("b_c5_gather_ready", {31'd0, gather_ro[1]}, 32'd0);
    check("b_c5_valid", {31'd0, cast_vo[1]}, 32'd0);
`ifdef PE_CTRL_STATS_EN
    check("b_stall_in", stall_in[1], 32'd4);
`endif
    cyc(); cyc(); #1;
    check("b_c7_valid", {31'd0, cast_vo[1]}, 32'd0);
    cyc(); cast_ri = 1'b1; #1;
    check("b_c8_valid", {31'd0, cast_vo[1]}, 32'd1);
    check("b_c8_data", {24'd0, cast_do[1]}, 32'd21);
    cyc(); #1;
    check("b_c9_count", count[1], 32'd1);
    check("b_c9_valid", {31'd0, cast_vo[1]}, 32'd0);
    check("b_c9_ready", {31'd0, cast_ro[1]}, 32'd1);

    // token 2: 200 + 100 + 0 wraps to 44
    cast_vi = 1'b1; cast_di = 8'd200;
    merge_vi = 1'b1; merge_di = 8'd100;
    gather_vi = 1'b1; gather_di = 8'd0;
    cyc(); cast_vi = 1'b0; merge_vi = 1'b0; gather_vi = 1'b0;
    cyc(); cyc(); cyc(); #1;
    check("b_wrap_valid", {31'd0, cast_vo[1]}, 32'd1);
    check("b_wrap_data", {24'd0, cast_do[1]}, 32'd44);
    cyc(); #1;
    check("b_wrap_count", count[1], 32'd2);

    // token 3 enters COMPUTE, then rst is pulsed
    cast_vi = 1'b1; merge_vi = 1'b1; gather_vi = 1'b1;
    cast_di = 8'd1; merge_di = 8'd1; gather_di = 8'd1;
    cyc(); cast_vi = 1'b0; merge_vi = 1'b0; gather_vi = 1'b0;
    rst[1] = 1'b1;
    #1;
    check("b_rst_in_compute_valid", {31'd0, cast_vo[1]}, 32'd0);
    cyc();
    rst[1] = 1'b0;
    cast_vi = 1'b1; merge_vi = 1'b1; gather_vi = 1'b1;
    cast_di = 8'd1; merge_di = 8'd2; gather_di = 8'd3;
    #1;
    check("b_post_rst_count", count[1], 32'd0);
    check("b_post_rst_valid", {31'd0, cast_vo[1]}, 32'd0);
    check("b_post_rst_mvalid", {31'd0, merge_vo[1]}, 32'd0);
    check("b_post_rst_gvalid", {31'd0, gather_vo[1]}, 32'd0);
    check("b_post_rst_done", {31'd0, done[1]}, 32'd0);
    check("b_post_rst_ready", {31'd0, cast_ro[1]}, 32'd1);
    check("b_post_rst_start", {31'd0, start[1]}, 32'd1);
    check("b_post_rst_stall_in", stall_in[1], 32'd0);
    check("b_post_rst_stall_out", stall_out[1], 32'd0);
    cyc(); cast_vi = 1'b0; merge_vi = 1'b0; gather_vi = 1'b0;
    cyc(); cyc(); cyc(); #1;
    check("b_fresh_valid", {31'd0, cast_vo[1]}, 32'd1);
    check("b_fresh_data", {24'd0, cast_do[1]}, 32'd6);
    cyc(); #1;
    check("b_fresh_count", count[1], 32'd1);
    rst[1] = 1'b1;

    // ---------------- instance 2: cast output stalled 5 cycles
    cyc();
    rst[2] = 1'b0;
    cast_vi = 1'b1; cast_di = 8'd42;
    cast_ri = 1'b0; gather_ri = 1'b1;
    cyc(); cast_vi = 1'b0; #1;
    check("c_compute_valid", {31'd0, cast_vo[2]}, 32'd0);
    cyc(); #1;
    check("c_e0_cast_valid", {31'd0, cast_vo[2]}, 32'd1);
    check("c_e0_gather_valid", {31'd0, gather_vo[2]}, 32'd1);
    check("c_e0_gather_data", {24'd0, gather_do[2]}, 32'd42);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("c_wait_cast_valid", {31'd0, cast_vo[2]}, 32'd1);
      check("c_wait_gather_valid", {31'd0, gather_vo[2]}, 32'd0);
      check("c_wait_cast_data", {24'd0, cast_do[2]}, 32'd42);
      check("c_wait_count", count[2], 32'd0);
    end
    cyc(); cast_ri = 1'b1; #1;
    check("c_accept_cast_valid", {31'd0, cast_vo[2]}, 32'd1);
    cyc(); #1;
    check("c_count_once", count[2], 32'd1);
    check("c_after_cast_valid", {31'd0, cast_vo[2]}, 32'd0);
    check("c_after_gather_valid", {31'd0, gather_vo[2]}, 32'd0);
`ifdef PE_CTRL_STATS_EN
    check("c_stall_out", stall_out[2], 32'd5);
`endif
    rst[2] = 1'b1;

    // ---------------- instance 3: merge-only output
    cyc();
    rst[3] = 1'b0;
    cast_vi = 1'b1; cast_di = 8'd3;
    cast_ri = 1'b1; merge_ri = 1'b1; gather_ri = 1'b1;
    #1;
    check("d_merge_ready", {31'd0, merge_ro[3]}, 32'd0);
    check("d_cast_ready", {31'd0, cast_ro[3]}, 32'd1);
    cyc(); cast_vi = 1'b0; #1;
    check("d_merge_valid", {31'd0, merge_vo[3]}, 32'd1);
    check("d_cast_valid", {31'd0, cast_vo[3]}, 32'd0);
    check("d_gather_valid", {31'd0, gather_vo[3]}, 32'd0);
    check("d_merge_data", {24'd0, merge_do[3]}, 32'd3);
    cyc(); #1;
    check("d_count", count[3], 32'd1);
    check("d_merge_valid_after", {31'd0, merge_vo[3]}, 32'd0);
    rst[3] = 1'b1;

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
